des_tdes_cbc_ctrl: RTL



---
 rtl/des_tdes_cbc_ctrl.sv | 193 +++++++++++++++++++
 1 files changed

// File: rtl/des_tdes_cbc_ctrl.sv
// CBC chaining controller around the Triple-DES pipeline core.
// Encrypt keeps one block in flight; decrypt streams with a FIFO of pending XOR operands.
module des_tdes_cbc_ctrl #(
  parameter int unsigned FIFO_DEPTH = 64,
  parameter int unsigned FIFO_AW    = 6
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cfg_start,
  input  logic [63:0] cfg_iv,
  input  logic        cfg_encrypt,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [63:0] in_block,
  input  logic        in_last,
  output logic        core_valid_out,
  output logic [63:0] core_block_out,
  output logic        core_is_encrypt,
  input  logic        core_valid_in,
  input  logic [63:0] core_block_in,
  output logic        out_valid,
  output logic [63:0] out_block,
  output logic        out_last,
  output logic        busy,
  output logic        err
);

  localparam logic [1:0] StIdle     = 2'd0;
  localparam logic [1:0] StEncIssue = 2'd1;
  localparam logic [1:0] StEncWait  = 2'd2;
  localparam logic [1:0] StDecRun   = 2'd3;

  localparam logic [FIFO_AW:0] FullCount = (FIFO_AW + 1)'(FIFO_DEPTH);

  logic [1:0]         state_q, state_d;
  logic [63:0]        chain_q, chain_d;
  logic               encrypt_q, encrypt_d;
  // Encrypt: latched last flag of the block in flight. Decrypt: last block accepted.
  logic               last_q, last_d;
  logic               err_q, err_d;
  logic               cvo_q, cvo_d;
  logic [63:0]        cbo_q, cbo_d;
  logic               ov_q, ov_d;
  logic [63:0]        ob_q, ob_d;
  logic               ol_q, ol_d;
  logic [FIFO_AW-1:0] wptr_q, wptr_d;
  logic [FIFO_AW-1:0] rptr_q, rptr_d;
  logic [FIFO_AW:0]   count_q, count_d;

  logic [64:0]        fifo_mem [FIFO_DEPTH];
  logic [64:0]        head;
  logic               fifo_full;
  logic               fifo_empty;
  logic               push;
  logic               pop;

  assign head       = fifo_mem[rptr_q];
  assign fifo_full  = (count_q == FullCount);
  assign fifo_empty = (count_q == '0);

  assign in_ready = (state_q == StEncIssue) ||
                    ((state_q == StDecRun) && !fifo_full && !last_q);

  always_comb begin
    state_d   = state_q;
    chain_d   = chain_q;
    encrypt_d = encrypt_q;
    last_d    = last_q;
    err_d     = err_q;
    cvo_d     = 1'b0;
    cbo_d     = cbo_q;
    ov_d      = 1'b0;
    ob_d      = ob_q;
    ol_d      = 1'b0;
    push      = 1'b0;
    pop       = 1'b0;

    case (state_q)
      StIdle: begin
        if (cfg_start) begin
          chain_d   = cfg_iv;
          encrypt_d = cfg_encrypt;
          last_d    = 1'b0;
          state_d   = cfg_encrypt ? StEncIssue : StDecRun;
        end
      end
      StEncIssue: begin
        if (in_valid) begin
          cvo_d   = 1'b1;
          cbo_d   = in_block ^ chain_q;
          last_d  = in_last;
          state_d = StEncWait;
        end
      end
      StEncWait: begin
        if (core_valid_in) begin
          ov_d    = 1'b1;
          ob_d    = core_block_in;
          ol_d    = last_q;
          chain_d = core_block_in;
          last_d  = 1'b0;
          state_d = last_q ? StIdle : StEncIssue;
        end
      end
      StDecRun: begin
        if (in_valid && in_ready) begin
          cvo_d   = 1'b1;
          cbo_d   = in_block;
          push    = 1'b1;
          chain_d = in_block;
          if (in_last) begin
            last_d = 1'b1;
          end
        end
        if (core_valid_in) begin
          if (fifo_empty) begin
            err_d = 1'b1;
          end else begin
            pop  = 1'b1;
            ov_d = 1'b1;
            ob_d = core_block_in ^ head[63:0];
            ol_d = head[64];
            if (head[64]) begin
              last_d  = 1'b0;
              state_d = StIdle;
            end
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    wptr_d  = push ? wptr_q + FIFO_AW'(1) : wptr_q;
    rptr_d  = pop ? rptr_q + FIFO_AW'(1) : rptr_q;
    count_d = count_q;
    case ({push, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= StIdle;
      chain_q   <= '0;
      encrypt_q <= 1'b0;
      last_q    <= 1'b0;
      err_q     <= 1'b0;
      cvo_q     <= 1'b0;
      cbo_q     <= '0;
      ov_q      <= 1'b0;
      ob_q      <= '0;
      ol_q      <= 1'b0;
      wptr_q    <= '0;
      rptr_q    <= '0;
      count_q   <= '0;
    end else begin
      state_q   <= state_d;
      chain_q   <= chain_d;
      encrypt_q <= encrypt_d;
      last_q    <= last_d;
      err_q     <= err_d;
      cvo_q     <= cvo_d;
      cbo_q     <= cbo_d;
      ov_q      <= ov_d;
      ob_q      <= ob_d;
      ol_q      <= ol_d;
      wptr_q    <= wptr_d;
      rptr_q    <= rptr_d;
      count_q   <= count_d;
    end
  end

  // Storage only; validity is tracked by the pointers and count.
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_mem[wptr_q] <= {in_last, chain_q};
    end
  end

  assign core_valid_out  = cvo_q;
  assign core_block_out  = cbo_q;
  assign core_is_encrypt = encrypt_q;
  assign out_valid       = ov_q;
  assign out_block       = ob_q;
  assign out_last        = ol_q;
  assign busy            = (state_q != StIdle);
  assign err             = err_q;

endmodule
